// File: rtl/riscv_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit.
package riscv_lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_load_ext.sv
// Selects the byte/half of a read word and sign- or zero-extends it.
module lsu_load_ext
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*off_i +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    data_o   = word_i;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: one valid/ready memory transaction per access, stalling until done.
module mem_stage_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FUNCT3_WIDTH = 3
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    MemReadM,
  input  logic                    MemWriteM,
  input  logic [DATA_WIDTH-1:0]   ALUResultM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  input  logic [FUNCT3_WIDTH-1:0] funct3M,
  output logic [DATA_WIDTH-1:0]   RD,
  output logic                    StallM,
  output logic                    FaultM,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [3:0]              mem_be,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata
);
  lsu_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d;
  logic [3:0]            be_q, be_d, lane_be;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d, off;
  logic                  we_q, we_d, access, fault;
  logic [DATA_WIDTH-1:0] lane_wdata, ext_data;

  assign access = MemReadM | MemWriteM;
  assign off    = ALUResultM[1:0];

  always_comb begin
    case (funct3M)
      F3_B, F3_BU: fault = 1'b0;
      F3_H, F3_HU: fault = off[0];
      F3_W:        fault = (off != 2'b00);
      default:     fault = 1'b1;
    endcase
  end

  // Stores place data on every lane; byte enables pick the real target.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = WriteDataM;
    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin lane_be = 4'b0001 << off; lane_wdata = {4{WriteDataM[7:0]}}; end
        2'b01: begin lane_be = 4'b0011 << off; lane_wdata = {2{WriteDataM[15:0]}}; end
        default: ;
      endcase
    end
  end

  lsu_load_ext u_ext (
    .word_i   (mem_rsp_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rd_d    = rd_q;
    StallM  = 1'b0;
    FaultM  = 1'b0;
    case (state_q)
      IDLE: if (access) begin
        if (fault) FaultM = 1'b1;
        else begin
          StallM  = 1'b1;
          addr_d  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
          wdata_d = lane_wdata;
          be_d    = lane_be;
          we_d    = MemWriteM;
          f3_d    = funct3M;
          off_d   = off;
          state_d = REQ;
        end
      end
      REQ: begin
        StallM = 1'b1;
        if (mem_req_ready) state_d = we_q ? DONE : RESP;
      end
      RESP: begin
        StallM = 1'b1;
        if (mem_rsp_valid) begin
          rd_d    = ext_data;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_be        = be_q;
  assign RD            = rd_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed plus randomized accesses against a behavioural model of the load/store unit.
module tb_mem_stage_lsu;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        MemReadM = 0, MemWriteM = 0;
  logic [31:0] ALUResultM = 0, WriteDataM = 0;
  logic [2:0]  funct3M = 0;
  logic [31:0] RD, mem_addr, mem_wdata;
  logic        StallM, FaultM, mem_req_valid, mem_we;
  logic [3:0]  mem_be;
  logic        mem_req_ready = 0, mem_rsp_valid = 0;
  logic [31:0] mem_rsp_rdata = 0;

  int checks = 0, failures = 0;
  logic [31:0] rd_model = 0;

  mem_stage_lsu dut (
    .CLK(CLK), .RST_N(RST_N), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
    .RD(RD), .StallM(StallM), .FaultM(FaultM), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_fault(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return (a % 4) != 0;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // One M-stage access; the bench plays the memory with the given wait counts.
  task automatic access(input bit st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int rdy_wait, input int rsp_wait,
                        input logic [31:0] rdata);
    logic [31:0] e_wdata; logic [3:0] e_be;
    int stalls = 0, hs = 0, hs_cyc = -1, reqc = 0;
    bit done = 0;
    MemReadM = !st; MemWriteM = st; ALUResultM = a; WriteDataM = wd; funct3M = f3;
    if (m_fault(f3, a)) begin
      mem_req_ready = 0; mem_rsp_valid = 0;
      #2;
      chk("fault_flag", {31'b0, FaultM}, 32'd1);
      chk("fault_stall", {31'b0, StallM}, 32'd0);
      chk("fault_req", {31'b0, mem_req_valid}, 32'd0);
      @(posedge CLK); #1;
      MemReadM = 0; MemWriteM = 0;
      #1;
      chk("fault_one_cycle", {31'b0, FaultM}, 32'd0);
      chk("fault_noreq", {31'b0, mem_req_valid}, 32'd0);
      chk("fault_rd", RD, rd_model);
      return;
    end
    e_be = 4'b1111; e_wdata = wd;
    if (st && f3[1:0] == 2'd0) begin e_be = 4'd1 << (a % 4); e_wdata = (wd & 32'hFF) * 32'h01010101; end
    if (st && f3[1:0] == 2'd1) begin e_be = 4'd3 << (a % 4); e_wdata = (wd & 32'hFFFF) * 32'h00010001; end
    for (int c = 0; c < 200 && !done; c++) begin
      mem_req_ready = mem_req_valid ? (reqc >= rdy_wait) : 1'($urandom % 2);
      if (!st && hs_cyc >= 0) begin
        mem_rsp_valid = (c - hs_cyc - 1 == rsp_wait);
        mem_rsp_rdata = mem_rsp_valid ? rdata : $urandom;
      end else begin
        mem_rsp_valid = 1'($urandom % 2);
        mem_rsp_rdata = $urandom;
      end
      #2;
      if (StallM) stalls++;
      else if (c > 0) done = 1;
      if (mem_req_valid) begin
        chk("req_addr", mem_addr, a & ~32'd3);
        chk("req_be", {28'b0, mem_be}, {28'b0, e_be});
        chk("req_we", {31'b0, mem_we}, {31'b0, st});
        if (st) chk("req_wdata", mem_wdata, e_wdata);
        reqc++;
        if (mem_req_ready) begin hs++; hs_cyc = c; end
      end
      @(posedge CLK); #1;
    end
    MemReadM = 0; MemWriteM = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    if (!done) chk("timeout", 32'd1, 32'd0);
    chk("handshakes", hs, 1);
    chk("stall_cycles", stalls, st ? 2 + rdy_wait : 3 + rdy_wait + rsp_wait);
    if (!st) rd_model = m_ext(f3, a, rdata);
    chk("rd", RD, rd_model);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rd", RD, 32'd0);
    chk("rst_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    RST_N = 1;
    @(posedge CLK); #1;
    chk("idle_stall", {31'b0, StallM}, 32'd0);

    access(0, 32'h100, 0, 3'b010, 0, 0, 32'hDEADBEEF);
    chk("lw_value", RD, 32'hDEADBEEF);
    access(0, 32'h103, 0, 3'b000, 0, 0, 32'h80FF7F01);
    chk("lb_value", RD, 32'hFFFFFF80);
    access(0, 32'h103, 0, 3'b100, 0, 0, 32'h80FF7F01);
    chk("lbu_value", RD, 32'h00000080);
    access(0, 32'h102, 0, 3'b001, 0, 0, 32'h80FF7F01);
    chk("lh_value", RD, 32'hFFFF80FF);
    access(1, 32'h101, 32'h123456AB, 3'b000, 0, 0, 0);
    access(1, 32'h102, 32'h123456AB, 3'b001, 0, 0, 0);
    access(0, 32'h200, 0, 3'b010, 5, 3, 32'hCAFEF00D);
    access(1, 32'h204, 32'h0BADC0DE, 3'b010, 5, 0, 0);
    access(0, 32'h102, 0, 3'b010, 0, 0, 0);
    access(1, 32'h101, 32'h5555, 3'b001, 0, 0, 0);
    access(0, 32'h100, 0, 3'b011, 0, 0, 0);

    for (int i = 0; i < 40; i++)
      access(1'($urandom % 2), $urandom_range(32'h3FF, 0), $urandom, 3'($urandom % 8),
             $urandom_range(3, 0), $urandom_range(3, 0), $urandom);

    // Reset in the middle of a request.
    MemReadM = 1; ALUResultM = 32'h300; funct3M = 3'b010; mem_req_ready = 0;
    @(posedge CLK); #1;
    chk("pre_rst_valid", {31'b0, mem_req_valid}, 32'd1);
    RST_N = 0;
    #1;
    chk("rst_async_valid", {31'b0, mem_req_valid}, 32'd0);
    MemReadM = 0;
    @(posedge CLK); #1;
    RST_N = 1;
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h12345678;
    @(posedge CLK); #1;
    mem_rsp_valid = 0;
    chk("post_rst_rd", RD, 32'd0);
    chk("post_rst_stall", {31'b0, StallM}, 32'd0);
    chk("post_rst_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("post_rst_we", {31'b0, mem_we}, 32'd0);
    chk("post_rst_wdata", mem_wdata, 32'd0);
    rd_model = 0;
    access(0, 32'h104, 0, 3'b101, 1, 1, 32'h89AB0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
